// File: rtl/nn_frame_buffer_if.sv
// nn_frame_buffer_if: pixel-source and CNN-reader signals of the frame buffer.
// The master side is the camera/CNN environment, the slave side is the buffer itself.
interface nn_frame_buffer_if #(
    parameter int PIX_W = 8,
    parameter int AW    = 10,
    parameter int CNT_W = 16
);
    logic             i_en;
    logic [9:0]       i_x;
    logic [9:0]       i_y;
    logic [PIX_W-1:0] i_pix;
    logic [AW-1:0]    i_rd_addr;
    logic [PIX_W-1:0] o_rd_data;
    logic             i_rd_lock;
    logic             o_frame_rdy;
    logic [CNT_W-1:0] o_frame_seq;
    logic [CNT_W-1:0] o_drop_cnt;

    modport master (
        output i_en, i_x, i_y, i_pix, i_rd_addr, i_rd_lock,
        input  o_rd_data, o_frame_rdy, o_frame_seq, o_drop_cnt
    );
    modport slave (
        input  i_en, i_x, i_y, i_pix, i_rd_addr, i_rd_lock,
        output o_rd_data, o_frame_rdy, o_frame_seq, o_drop_cnt
    );
endinterface

// File: rtl/nn_frame_buffer.sv
// nn_frame_buffer: crops and box-averages a raster pixel stream into a ping-pong frame RAM.
// Define NN_FB_DROP_CNT_EN to implement the dropped-frame counter (otherwise it reads 0).
module nn_frame_buffer #(
    parameter int DST_W = 32,
    parameter int DST_H = 32,
    parameter int SHX   = 3,
    parameter int SHY   = 3,
    parameter int X0    = 32,
    parameter int Y0    = 0,
    parameter int PIX_W = 8,
    parameter int CNT_W = 16
) (
    input logic CLK,
    input logic RST,
    nn_frame_buffer_if.slave bus
);
    localparam int DXW   = $clog2(DST_W);
    localparam int DYW   = $clog2(DST_H);
    localparam int AW    = DXW + DYW;
    localparam int ACC_W = PIX_W + SHX + SHY;
    localparam int WIN_W = DST_W << SHX;
    localparam int WIN_H = DST_H << SHY;
    localparam logic [9:0] MSK_X = 10'((1 << SHX) - 1);
    localparam logic [9:0] MSK_Y = 10'((1 << SHY) - 1);

    typedef enum logic [1:0] {IDLE, FILL, DECIDE} state_t;

    state_t           r_state, w_nstate;
    logic [PIX_W-1:0] r_ram [2**(AW+1)];
    logic [ACC_W-1:0] r_acc [DST_W];
    logic             r_bank, r_we, r_wlast, r_rdy;
    logic [AW-1:0]    r_waddr;
    logic [PIX_W-1:0] r_wdat, r_rd_data;
    logic [CNT_W-1:0] r_seq;
    logic [31:0]      w_x32, w_y32;
    logic [9:0]       w_rx, w_ry;
    logic [DXW-1:0]   w_dx;
    logic [DYW-1:0]   w_dy;
    logic             w_start, w_in, w_go, w_s0, w_blk_end, w_last;
    logic [ACC_W-1:0] w_sum;

    assign w_x32     = 32'(bus.i_x);
    assign w_y32     = 32'(bus.i_y);
    assign w_in      = w_x32 >= 32'(X0) && w_x32 < 32'(X0 + WIN_W) &&
                       w_y32 >= 32'(Y0) && w_y32 < 32'(Y0 + WIN_H);
    assign w_rx      = bus.i_x - 10'(X0);
    assign w_ry      = bus.i_y - 10'(Y0);
    assign w_dx      = DXW'(w_rx >> SHX);
    assign w_dy      = DYW'(w_ry >> SHY);
    assign w_s0      = (w_rx & MSK_X) == 10'd0 && (w_ry & MSK_Y) == 10'd0;
    assign w_blk_end = (w_rx & MSK_X) == MSK_X && (w_ry & MSK_Y) == MSK_Y;
    assign w_last    = w_dx == DXW'(DST_W - 1) && w_dy == DYW'(DST_H - 1);
    assign w_start   = bus.i_en && bus.i_x == 10'd0 && bus.i_y == 10'd0;
    // the (0,0) pixel is accepted in every state, so it also starts the next frame from DECIDE
    assign w_go      = bus.i_en && w_in && (w_start || r_state == FILL);
    assign w_sum     = (w_s0 ? ACC_W'(0) : r_acc[w_dx]) + ACC_W'(bus.i_pix);

    always_comb begin
        w_nstate = r_state;
        w_nstate = (r_state == FILL && r_wlast) ? DECIDE :
                   w_start                      ? FILL   :
                   (r_state == DECIDE)          ? IDLE   : r_state;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_bank    <= 1'b0;
            r_we      <= 1'b0;
            r_wlast   <= 1'b0;
            r_waddr   <= '0;
            r_wdat    <= '0;
            r_rd_data <= '0;
            r_rdy     <= 1'b0;
            r_seq     <= '0;
        end else begin
            r_state   <= w_nstate;
            r_we      <= w_go && w_blk_end;
            r_wlast   <= w_go && w_blk_end && w_last;
            r_waddr   <= {w_dy, w_dx};
            r_wdat    <= PIX_W'(w_sum >> (SHX + SHY));
            r_rd_data <= r_ram[{~r_bank, bus.i_rd_addr}];
            if (r_state == DECIDE && !bus.i_rd_lock) begin
                r_bank <= ~r_bank;
                r_rdy  <= 1'b1;
                r_seq  <= r_seq + 1'b1;
            end else if (bus.i_rd_lock) begin
                r_rdy <= 1'b0;
            end
        end
    end

    // storage needs no reset: every word is rewritten before its bank becomes readable
    always_ff @(posedge CLK) begin
        if (r_we) r_ram[{r_bank, r_waddr}] <= r_wdat;
        if (w_go) r_acc[w_dx] <= w_sum;
    end

`ifdef NN_FB_DROP_CNT_EN
    logic [CNT_W-1:0] r_drop;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_drop <= '0;
        else if (r_state == DECIDE && bus.i_rd_lock) r_drop <= r_drop + 1'b1;
    end
    assign bus.o_drop_cnt = r_drop;
`else
    assign bus.o_drop_cnt = '0;
`endif

    assign bus.o_rd_data   = r_rd_data;
    assign bus.o_frame_rdy = r_rdy;
    assign bus.o_frame_seq = r_seq;
endmodule

// File: tb/tb_nn_frame_buffer.sv
// tb_nn_frame_buffer: directed frame sequences with random pixels, checked against an
// image-level model of crop, box-average and ping-pong publication.
module tb_nn_frame_buffer;
    localparam int DW = 4, DH = 4, SX = 1, SY = 1, X0 = 3, Y0 = 2;
    localparam int PW = 8, CW = 16, AW = 4, SRC_W = 14;
    localparam int WW = DW << SX, WH = DH << SY, N = DW * DH;
    localparam int LY = Y0 + WH - 1, LX = X0 + WW - 1;
`ifdef NN_FB_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int total = 0;
    int bad = 0;
    int exp_seq = 0;
    int exp_drop = 0;
    logic [7:0] img [Y0+WH][SRC_W];
    logic [7:0] vis [N];
    logic [7:0] nxt [N];

    nn_frame_buffer_if #(.PIX_W(PW), .AW(AW), .CNT_W(CW)) bus ();

    nn_frame_buffer #(
        .DST_W(DW), .DST_H(DH), .SHX(SX), .SHY(SY), .X0(X0), .Y0(Y0), .PIX_W(PW), .CNT_W(CW)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // mode 0: random everywhere, 1: pixel = x inside window and 0 outside, 2: constant 0x80 inside
    task automatic gen(input int mode);
        for (int y = 0; y < Y0 + WH; y++)
            for (int x = 0; x < SRC_W; x++) begin
                bit in_win;
                in_win = x >= X0 && x < X0 + WW && y >= Y0 && y < Y0 + WH;
                img[y][x] = mode == 0 ? 8'($urandom) : !in_win ? 8'h00 : mode == 1 ? 8'(x) : 8'h80;
            end
        for (int dy = 0; dy < DH; dy++)
            for (int dx = 0; dx < DW; dx++) begin
                int s;
                s = 0;
                for (int sy = 0; sy < (1 << SY); sy++)
                    for (int sx = 0; sx < (1 << SX); sx++)
                        s += int'(img[Y0 + dy * (1 << SY) + sy][X0 + dx * (1 << SX) + sx]);
                nxt[dy * DW + dx] = 8'(s / (1 << (SX + SY)));
            end
    endtask

    task automatic send(input int last_y, input int last_x);
        for (int y = 0; y <= last_y; y++)
            for (int x = 0; x < SRC_W; x++)
                if (!(y == last_y && x > last_x)) begin
                    bus.i_en  = 1'b1;
                    bus.i_x   = 10'(x);
                    bus.i_y   = 10'(y);
                    bus.i_pix = img[y][x];
                    @(posedge CLK); #1;
                end
        bus.i_en = 1'b0;
    endtask

    // called #1 after the edge that sampled the last window pixel
    task automatic settle(input string tag);
        @(posedge CLK); #1;
        chk({tag, "_seq_early"}, 32'(bus.o_frame_seq), 32'(exp_seq));
        @(posedge CLK); #1;
        if (bus.i_rd_lock) exp_drop++;
        else begin
            exp_seq++;
            vis = nxt;
        end
        chk({tag, "_seq"}, 32'(bus.o_frame_seq), 32'(exp_seq));
        chk({tag, "_drop"}, 32'(bus.o_drop_cnt), DROP_EN ? 32'(exp_drop) : 32'd0);
        chk({tag, "_rdy"}, 32'(bus.o_frame_rdy), 32'(!bus.i_rd_lock));
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < N; a++) begin
            bus.i_rd_addr = AW'(a);
            @(posedge CLK); #1;
            chk($sformatf("%s_rd%0d", tag, a), 32'(bus.o_rd_data), 32'(vis[a]));
        end
    endtask

    initial begin
        bus.i_en = 1'b0;
        bus.i_x = '0;
        bus.i_y = '0;
        bus.i_pix = '0;
        bus.i_rd_addr = '0;
        bus.i_rd_lock = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_rdy", 32'(bus.o_frame_rdy), 32'd0);
        chk("rst_seq", 32'(bus.o_frame_seq), 32'd0);
        chk("rst_drop", 32'(bus.o_drop_cnt), 32'd0);
        chk("rst_rd", 32'(bus.o_rd_data), 32'd0);
        RST = 1'b1;
        @(posedge CLK); #1;

        gen(2);
        send(LY, LX);
        settle("const");
        read_all("const");

        gen(1);
        send(LY, LX);
        settle("ramp");
        read_all("ramp");

        bus.i_rd_lock = 1'b1;
        @(posedge CLK); #1;
        chk("lock_rdy_clr", 32'(bus.o_frame_rdy), 32'd0);
        gen(0);
        send(LY, LX);
        settle("locked");
        read_all("locked");
        bus.i_rd_lock = 1'b0;

        gen(0);
        send(4, 13);
        gen(0);
        send(LY, LX);
        settle("restart");
        read_all("restart");

        gen(0);
        send(5, 6);
        RST = 1'b0;
        #1;
        chk("arst_rdy", 32'(bus.o_frame_rdy), 32'd0);
        chk("arst_seq", 32'(bus.o_frame_seq), 32'd0);
        chk("arst_drop", 32'(bus.o_drop_cnt), 32'd0);
        chk("arst_rd", 32'(bus.o_rd_data), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        exp_seq = 0;
        exp_drop = 0;
        gen(0);
        send(LY, LX);
        settle("post_rst");
        read_all("post_rst");

        for (int k = 0; k < 3; k++) begin
            bus.i_rd_lock = 1'($urandom_range(0, 1));
            gen(0);
            send(LY, LX);
            settle($sformatf("rnd%0d", k));
            read_all($sformatf("rnd%0d", k));
        end
        bus.i_rd_lock = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
